// File: rtl/simmem_pkg.sv
// Shared dimensions, timing costs and types for the simulated DRAM memory model.
package simmem_pkg;

  localparam int AxAddrWidth = 16;
  localparam int RowBufferLenWidth = 8;
  localparam int RowIdWidth = AxAddrWidth - RowBufferLenWidth;

  localparam int WriteRespBankAddrWidth = 6;
  localparam int ReadDataBankAddrWidth = 5;
  localparam int ReleaseIidWidth = (WriteRespBankAddrWidth > ReadDataBankAddrWidth) ?
                                   WriteRespBankAddrWidth : ReadDataBankAddrWidth;

  // DRAM timing in core cycles; every phase costs at least one cycle.
  localparam int RowHitCost = 4;
  localparam int PrechargeCost = 2;
  localparam int ActivationCost = 1;

  typedef logic [RowIdWidth-1:0] row_id_t;
  typedef logic [ReleaseIidWidth-1:0] release_iid_t;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    ACCESS,
    RELEASE
  } sched_state_e;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Two-way (read/write) round-robin arbiter; combinational grant, pointer moves
// away from the granted side only when ptr_upd_en is high. Reset favours read.
module simmem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic r_req,
  input  logic w_req,
  input  logic ptr_upd_en,
  output logic r_gnt,
  output logic w_gnt
);

  logic prefer_read_q;

  always_comb begin
    r_gnt = r_req && (!w_req || prefer_read_q);
    w_gnt = w_req && (!r_req || !prefer_read_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_read_q <= 1'b1;
    end else if (ptr_upd_en && (r_gnt || w_gnt)) begin
      prefer_read_q <= w_gnt;
    end
  end

endmodule

// File: rtl/simmem_row_scheduler.sv
// Single-bank open-page scheduler: one request at a time, release token after
// hit/closed/miss latency; holds release under backpressure. Option: SIMMEM_ROW_HIT_PRIORITY_EN.
module simmem_row_scheduler
  import simmem_pkg::*;
#(
  parameter int RowHitCost     = simmem_pkg::RowHitCost,
  parameter int PrechargeCost  = simmem_pkg::PrechargeCost,
  parameter int ActivationCost = simmem_pkg::ActivationCost
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              w_req_valid_i,
  output logic                              w_req_ready_o,
  input  logic [AxAddrWidth-1:0]            w_req_addr_i,
  input  logic [WriteRespBankAddrWidth-1:0] w_req_iid_i,
  input  logic                              r_req_valid_i,
  output logic                              r_req_ready_o,
  input  logic [AxAddrWidth-1:0]            r_req_addr_i,
  input  logic [ReadDataBankAddrWidth-1:0]  r_req_iid_i,
  output logic                              release_valid_o,
  input  logic                              release_ready_i,
  output logic                              release_is_write_o,
  output logic [ReleaseIidWidth-1:0]        release_iid_o,
  output logic                              release_row_hit_o,
  output logic                              open_row_valid_o,
  output logic [RowIdWidth-1:0]             open_row_o
);

  localparam int MaxCost0 = (RowHitCost > PrechargeCost) ? RowHitCost : PrechargeCost;
  localparam int MaxCost  = (MaxCost0 > ActivationCost) ? MaxCost0 : ActivationCost;
  localparam int CntWidth = $clog2(MaxCost + 1);

  typedef logic [CntWidth-1:0] cnt_t;

  sched_state_e state_q, state_d;
  cnt_t         cnt_q, cnt_d;

  logic         req_is_write_q;
  release_iid_t req_iid_q;
  row_id_t      req_row_q;
  logic         req_hit_q;

  row_id_t      open_row_q;
  logic         open_row_valid_q;

  logic         idle;
  logic         phase_done;
  row_id_t      w_row, r_row, sel_row;
  logic         arb_r_gnt, arb_w_gnt, ptr_upd_en;
  logic         w_ready, r_ready;
  logic         accept, sel_is_write, sel_hit;

  // Column bits within the row buffer do not influence scheduling.
  logic         unused_addr_lsbs;
  assign unused_addr_lsbs = ^{w_req_addr_i[RowBufferLenWidth-1:0],
                              r_req_addr_i[RowBufferLenWidth-1:0]};

  assign idle       = (state_q == IDLE);
  assign phase_done = (cnt_q == cnt_t'(1));
  assign w_row      = w_req_addr_i[AxAddrWidth-1:RowBufferLenWidth];
  assign r_row      = r_req_addr_i[AxAddrWidth-1:RowBufferLenWidth];

  simmem_rr_arbiter u_rr_arbiter (
    .clk        (clk_i),
    .rst        (rst_i),
    .r_req      (idle && r_req_valid_i),
    .w_req      (idle && w_req_valid_i),
    .ptr_upd_en (ptr_upd_en),
    .r_gnt      (arb_r_gnt),
    .w_gnt      (arb_w_gnt)
  );

`ifdef SIMMEM_ROW_HIT_PRIORITY_EN
  logic w_hit, r_hit, hit_pick;
  assign w_hit    = open_row_valid_q && (open_row_q == w_row);
  assign r_hit    = open_row_valid_q && (open_row_q == r_row);
  // A lone row hit overrides round-robin and leaves the pointer untouched.
  assign hit_pick = w_req_valid_i && r_req_valid_i && (w_hit != r_hit);
  assign w_ready  = idle && (hit_pick ? w_hit : arb_w_gnt);
  assign r_ready  = idle && (hit_pick ? r_hit : arb_r_gnt);
  assign ptr_upd_en = !hit_pick;
`else
  assign w_ready    = arb_w_gnt;
  assign r_ready    = arb_r_gnt;
  assign ptr_upd_en = 1'b1;
`endif

  assign accept       = w_ready || r_ready;
  assign sel_is_write = w_ready;
  assign sel_row      = w_ready ? w_row : r_row;
  assign sel_hit      = open_row_valid_q && (open_row_q == sel_row);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_hit) begin
            state_d = ACCESS;
            cnt_d   = cnt_t'(RowHitCost);
          end else if (!open_row_valid_q) begin
            state_d = ACTIVATE;
            cnt_d   = cnt_t'(ActivationCost);
          end else begin
            state_d = PRECHARGE;
            cnt_d   = cnt_t'(PrechargeCost);
          end
        end
      end
      PRECHARGE: begin
        if (phase_done) begin
          state_d = ACTIVATE;
          cnt_d   = cnt_t'(ActivationCost);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ACTIVATE: begin
        if (phase_done) begin
          state_d = ACCESS;
          cnt_d   = cnt_t'(RowHitCost);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ACCESS: begin
        if (phase_done) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      RELEASE: begin
        if (release_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_is_write_q   <= 1'b0;
      req_iid_q        <= '0;
      req_row_q        <= '0;
      req_hit_q        <= 1'b0;
      open_row_q       <= '0;
      open_row_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        req_is_write_q <= sel_is_write;
        req_iid_q      <= sel_is_write ? release_iid_t'(w_req_iid_i)
                                       : release_iid_t'(r_req_iid_i);
        req_row_q      <= sel_row;
        req_hit_q      <= sel_hit;
      end
      if (state_q == PRECHARGE && phase_done) begin
        open_row_valid_q <= 1'b0;
      end
      if (state_q == ACTIVATE && phase_done) begin
        open_row_q       <= req_row_q;
        open_row_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    w_req_ready_o      = w_ready;
    r_req_ready_o      = r_ready;
    release_valid_o    = (state_q == RELEASE);
    release_is_write_o = release_valid_o && req_is_write_q;
    release_iid_o      = release_valid_o ? req_iid_q : '0;
    release_row_hit_o  = release_valid_o && req_hit_q;
    open_row_valid_o   = open_row_valid_q;
    open_row_o         = open_row_q;
  end

endmodule

// File: tb/tb_simmem_row_scheduler.sv
// Directed bench for simmem_row_scheduler: latency per row state, arbitration,
// release backpressure and asynchronous reset mid-precharge.
module tb_simmem_row_scheduler;
  import simmem_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst = 1'b1;
  logic                              w_req_valid = 1'b0;
  logic                              w_req_ready;
  logic [AxAddrWidth-1:0]            w_req_addr = '0;
  logic [WriteRespBankAddrWidth-1:0] w_req_iid = '0;
  logic                              r_req_valid = 1'b0;
  logic                              r_req_ready;
  logic [AxAddrWidth-1:0]            r_req_addr = '0;
  logic [ReadDataBankAddrWidth-1:0]  r_req_iid = '0;
  logic                              release_valid;
  logic                              release_ready = 1'b0;
  logic                              release_is_write;
  logic [ReleaseIidWidth-1:0]        release_iid;
  logic                              release_row_hit;
  logic                              open_row_valid;
  logic [RowIdWidth-1:0]             open_row;

  int checks = 0;
  int failures = 0;

  simmem_row_scheduler dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .w_req_valid_i      (w_req_valid),
    .w_req_ready_o      (w_req_ready),
    .w_req_addr_i       (w_req_addr),
    .w_req_iid_i        (w_req_iid),
    .r_req_valid_i      (r_req_valid),
    .r_req_ready_o      (r_req_ready),
    .r_req_addr_i       (r_req_addr),
    .r_req_iid_i        (r_req_iid),
    .release_valid_o    (release_valid),
    .release_ready_i    (release_ready),
    .release_is_write_o (release_is_write),
    .release_iid_o      (release_iid),
    .release_row_hit_o  (release_row_hit),
    .open_row_valid_o   (open_row_valid),
    .open_row_o         (open_row)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, checks it is accepted immediately, then drops valid.
  task automatic issue(input bit is_w, input logic [15:0] addr, input logic [5:0] iid,
                       input string tag);
    if (is_w) begin
      w_req_valid = 1'b1; w_req_addr = addr; w_req_iid = iid;
    end else begin
      r_req_valid = 1'b1; r_req_addr = addr; r_req_iid = iid[4:0];
    end
    #1;
    chk({tag, "_ready"}, {30'd0, w_req_ready, r_req_ready}, is_w ? 32'd2 : 32'd1);
    tick();
    w_req_valid = 1'b0;
    r_req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until release_valid is seen.
  task automatic wait_release(output int lat, output bit saw_closed, output int busy_rdy);
    lat = 0; saw_closed = 1'b0; busy_rdy = 0;
    do begin
      tick();
      lat++;
      if (!open_row_valid) saw_closed = 1'b1;
      if (w_req_ready || r_req_ready) busy_rdy++;
    end while (!release_valid && lat < 40);
  endtask

  task automatic consume();
    release_ready = 1'b1;
    tick();
    release_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit closed;
    int busy, busy_total, both_cnt, n;
    bit exp_first_w, exp_w;

    busy_total = 0;
    both_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_release_valid", {31'd0, release_valid}, 32'd0);
    chk("rst_open_row_valid", {31'd0, open_row_valid}, 32'd0);
    chk("rst_open_row", {24'd0, open_row}, 32'd0);
    chk("rst_iid", {26'd0, release_iid}, 32'd0);
    rst = 1'b0;
    tick();

    // Closed bank: activate + access.
    issue(1'b0, 16'h0100, 6'd3, "closed");
    wait_release(lat, closed, busy);
    chk("closed_latency", lat, 32'd5);
    chk("closed_is_write", {31'd0, release_is_write}, 32'd0);
    chk("closed_iid", {26'd0, release_iid}, 32'd3);
    chk("closed_row_hit", {31'd0, release_row_hit}, 32'd0);
    chk("closed_open_row", {24'd0, open_row}, 32'h01);
    chk("closed_open_row_valid", {31'd0, open_row_valid}, 32'd1);
    consume();

    // Same row: hit.
    issue(1'b1, 16'h01F0, 6'd17, "hit");
    wait_release(lat, closed, busy);
    chk("hit_latency", lat, 32'd4);
    chk("hit_is_write", {31'd0, release_is_write}, 32'd1);
    chk("hit_iid", {26'd0, release_iid}, 32'd17);
    chk("hit_row_hit", {31'd0, release_row_hit}, 32'd1);
    consume();

    // Different row: precharge + activate + access.
    issue(1'b0, 16'h0300, 6'd5, "miss");
    wait_release(lat, closed, busy);
    chk("miss_latency", lat, 32'd7);
    chk("miss_row_closed_seen", {31'd0, closed}, 32'd1);
    chk("miss_open_row", {24'd0, open_row}, 32'h03);
    chk("miss_row_hit", {31'd0, release_row_hit}, 32'd0);
    consume();

    // Both valid, only the write hits row 3; pointer also favours write here.
    r_req_valid = 1'b1; r_req_addr = 16'h0500; r_req_iid = 5'd9;
    w_req_valid = 1'b1; w_req_addr = 16'h0310; w_req_iid = 6'd21;
    #1;
    chk("prio_grant", {30'd0, w_req_ready, r_req_ready}, 32'd2);
    tick();
    w_req_valid = 1'b0; r_req_valid = 1'b0;
    wait_release(lat, closed, busy);
    chk("prio_latency", lat, 32'd4);
    chk("prio_iid", {26'd0, release_iid}, 32'd21);
    chk("prio_is_write", {31'd0, release_is_write}, 32'd1);
    consume();

    // Both valid and both hitting row 3: strict alternation.
`ifdef SIMMEM_ROW_HIT_PRIORITY_EN
    exp_first_w = 1'b1;
`else
    exp_first_w = 1'b0;
`endif
    r_req_valid = 1'b1; r_req_addr = 16'h0320; r_req_iid = 5'd2;
    w_req_valid = 1'b1; w_req_addr = 16'h0330; w_req_iid = 6'd30;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_w = exp_first_w ^ g[0];
      n = 0;
      while (!(w_req_ready || r_req_ready) && n < 10) begin
        tick();
        n++;
      end
      if (w_req_ready && r_req_ready) both_cnt++;
      chk("alt_grant", {30'd0, w_req_ready, r_req_ready}, exp_w ? 32'd2 : 32'd1);
      tick();
      wait_release(lat, closed, busy);
      busy_total += busy;
      chk("alt_latency", lat, 32'd4);
      chk("alt_is_write", {31'd0, release_is_write}, {31'd0, exp_w});
      consume();
    end
    w_req_valid = 1'b0; r_req_valid = 1'b0;
    chk("alt_both_ready", both_cnt, 32'd0);
    chk("alt_ready_while_busy", busy_total, 32'd0);

    // Release backpressure with a write waiting.
    issue(1'b0, 16'h0340, 6'd7, "hold");
    wait_release(lat, closed, busy);
    chk("hold_latency", lat, 32'd4);
    w_req_valid = 1'b1; w_req_addr = 16'h0350; w_req_iid = 6'd1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_stable",
          {21'd0, release_valid, release_is_write, release_iid, release_row_hit,
           w_req_ready, r_req_ready},
          {21'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0});
    end
    w_req_valid = 1'b0;
    consume();

    // Reset while precharging row 3 for row 7.
    issue(1'b0, 16'h0700, 6'd4, "rst_pre");
    tick();
    chk("pre_row_still_open", {31'd0, open_row_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        {19'd0, release_valid, release_is_write, release_iid, release_row_hit,
         w_req_ready, r_req_ready, open_row_valid},
        32'd0);
    chk("midrst_open_row", {24'd0, open_row}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    issue(1'b0, 16'h0700, 6'd4, "after_rst");
    wait_release(lat, closed, busy);
    chk("after_rst_latency", lat, 32'd5);
    chk("after_rst_open_row", {24'd0, open_row}, 32'h07);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
